// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - Fetch-stage bus bundle: instruction ROM port plus IF/ID handshake.
//
// Purpose: groups the instruction-memory read port and the IF/ID valid/ready
// handshake into one bundle so the fetch stage and its neighbours connect
// through a single port.
//
// Signals:
//   imem_addr  ADDR_WIDTH  word address to the asynchronous-read ROM
//   imem_data  32          instruction returned for imem_addr in the same cycle
//   id_valid   1           IF/ID register holds a real instruction
//   id_ready   1           decode accepts id_instr/id_pc this cycle
//   id_instr   32          registered instruction
//   id_pc      32          byte address of id_instr
//
// Modports:
//   master  fetch-stage side (drives imem_addr and the IF/ID outputs)
//   slave   ROM/decode side (drives imem_data and id_ready)

interface if_stage_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_instr;
  logic [31:0]           id_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - Instruction-fetch stage with PC, IF/ID register and fetch counter.
//
// Purpose: owns the program counter, addresses the asynchronous instruction
// ROM, captures the returned word into the IF/ID register and hands it to
// decode over a valid/ready handshake. Handles redirects (which flush IF/ID),
// decode back-pressure and halt, and counts instructions accepted by decode.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   bus             if_stage_if.master: imem_addr/imem_data, id_valid/id_ready/id_instr/id_pc
//   redirect_valid  taken branch/jump; overrides everything except rst
//   redirect_pc     redirect target byte address (bits [1:0] treated as 0)
//   halt            level; while high no new instruction enters IF/ID
//   pc              current fetch PC (debug/trace)
//   fetch_count     instructions accepted by decode, wraps modulo 2^32

module if_stage #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        bus,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic [31:0]       pc,
  output logic [31:0]       fetch_count
);

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] count_q;

  logic        transfer;
  logic        advance;
  logic [31:0] redirect_target;

  assign transfer        = valid_q && bus.id_ready;
  // IF/ID can take a new word when it is empty or its occupant leaves now.
  assign advance         = !valid_q || bus.id_ready;
  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // ROM address comes straight from the PC register, never from id_ready or
  // redirect inputs; addresses beyond the ROM depth alias by truncation.
  assign bus.imem_addr = pc_q[ADDR_WIDTH+1:2];
  assign bus.id_valid  = valid_q;
  assign bus.id_instr  = instr_q;
  assign bus.id_pc     = id_pc_q;
  assign pc            = pc_q;
  assign fetch_count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      id_pc_q <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Flush IF/ID even if decode is accepting this cycle; id_pc keeps its value.
      pc_q    <= redirect_target;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (advance) begin
      if (halt) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end else begin
        instr_q <= bus.imem_data;
        id_pc_q <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_q + 32'd4;
      end
    end
    // Stall (advance=0): everything holds so id_instr stays stable.
  end

  // Counted independently of the redirect/halt priority: a transfer that
  // coincides with a redirect still retired into decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'h0000_0000;
    end else if (transfer) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Scoreboard testbench for if_stage.

module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] fetch_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] id_pc;
    logic [31:0] instr;
  } xfer_t;

  xfer_t exp_q[$];

  if_stage_if #(.ADDR_WIDTH(10)) bus ();

  if_stage #(
    .ADDR_WIDTH(10),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .pc            (pc),
    .fetch_count   (fetch_count)
  );

  // ROM model: word i holds 32'h1000_0000 + i.
  assign bus.imem_data = 32'h1000_0000 + {22'b0, bus.imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] p);
    xfer_t x;
    x.id_pc = p;
    x.instr = 32'h1000_0000 + {22'b0, p[11:2]};
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_xfer: got id_pc %h with empty scoreboard", bus.id_pc);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("xfer_id_pc", bus.id_pc, e.id_pc);
        check("xfer_instr", bus.id_instr, e.instr);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    bus.id_ready   = 1'b1;
    step();
    step();
    check("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst_instr", bus.id_instr, 32'h0000_0013);
    check("rst_id_pc", bus.id_pc, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_imem_addr", {22'b0, bus.imem_addr}, 32'h0);

    // Free-run, then stall with id_pc=0x8.
    push(32'h0);
    push(32'h4);
    rst = 1'b0;
    step();
    check("first_valid", {31'b0, bus.id_valid}, 32'd1);
    check("first_id_pc", bus.id_pc, 32'h0);
    step();
    step();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_id_pc", bus.id_pc, 32'h8);
      check("stall_instr", bus.id_instr, 32'h1000_0002);
      check("stall_pc", pc, 32'hC);
      check("stall_count", fetch_count, 32'd2);
    end
    for (int i = 0; i < 6; i++) push(32'h8 + 32'(4 * i));
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("count_8", fetch_count, 32'd8);
    check("id_pc_20", bus.id_pc, 32'h20);

    // Redirect into a stall.
    bus.id_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    check("redir_valid", {31'b0, bus.id_valid}, 32'd0);
    check("redir_instr", bus.id_instr, 32'h0000_0013);
    check("redir_pc", pc, 32'h100);
    check("redir_id_pc_hold", bus.id_pc, 32'h20);
    check("redir_count", fetch_count, 32'd8);
    redirect_valid = 1'b0;
    bus.id_ready   = 1'b1;
    push(32'h100);
    step();
    check("after_redir_id_pc", bus.id_pc, 32'h100);
    check("after_redir_instr", bus.id_instr, 32'h1000_0040);
    check("after_redir_addr", {22'b0, bus.imem_addr}, 32'h41);

    // Redirect coinciding with a transfer still counts it.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    check("redir_xfer_count", fetch_count, 32'd9);
    check("redir_xfer_valid", {31'b0, bus.id_valid}, 32'd0);
    check("redir_xfer_addr", {22'b0, bus.imem_addr}, 32'h80);
    redirect_valid = 1'b0;
    push(32'h200);
    step();
    check("fetch_200_pc", pc, 32'h204);

    // Halt during free-run.
    halt = 1'b1;
    step();
    check("halt_valid", {31'b0, bus.id_valid}, 32'd0);
    check("halt_pc", pc, 32'h204);
    check("halt_count", fetch_count, 32'd10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_hold_valid", {31'b0, bus.id_valid}, 32'd0);
      check("halt_hold_pc", pc, 32'h204);
    end
    halt = 1'b0;
    push(32'h204);
    push(32'h208);
    step();
    check("resume_id_pc", bus.id_pc, 32'h204);
    step();
    check("resume_id_pc2", bus.id_pc, 32'h208);
    check("resume_count", fetch_count, 32'd11);

    // Halt while stalled: held instruction stays valid until accepted.
    bus.id_ready = 1'b0;
    halt         = 1'b1;
    step();
    check("halt_stall_valid", {31'b0, bus.id_valid}, 32'd1);
    check("halt_stall_id_pc", bus.id_pc, 32'h208);
    bus.id_ready = 1'b1;
    step();
    check("halt_stall_drop", {31'b0, bus.id_valid}, 32'd0);
    check("halt_stall_count", fetch_count, 32'd12);
    check("halt_stall_pc", pc, 32'h20C);
    halt = 1'b0;

    // PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_addr_top", {22'b0, bus.imem_addr}, 32'h3FF);
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC);
    step();
    check("wrap_id_pc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap_pc0", pc, 32'h0);
    check("wrap_addr0", {22'b0, bus.imem_addr}, 32'h0);
    step();
    bus.id_ready = 1'b0;
    check("wrap_id_pc0", bus.id_pc, 32'h0);
    check("wrap_instr0", bus.id_instr, 32'h1000_0000);
    check("wrap_count", fetch_count, 32'd13);

    // Reset mid-stall.
    step();
    step();
    check("stall2_id_pc", bus.id_pc, 32'h0);
    check("stall2_pc", pc, 32'h4);
    rst = 1'b1;
    step();
    check("rst2_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst2_instr", bus.id_instr, 32'h0000_0013);
    check("rst2_pc", pc, 32'h0);
    check("rst2_count", fetch_count, 32'h0);

    // Continuous redirect: IF/ID stays empty, pc tracks the target.
    rst            = 1'b0;
    bus.id_ready   = 1'b1;
    redirect_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      redirect_pc = 32'(64 * i);
      step();
      check("cont_redir_valid", {31'b0, bus.id_valid}, 32'd0);
      check("cont_redir_pc", pc, 32'(64 * i));
    end
    redirect_valid = 1'b0;
    bus.id_ready   = 1'b0;
    step();
    check("post_redir_id_pc", bus.id_pc, 32'hC0);
    check("post_redir_instr", bus.id_instr, 32'h1000_0030);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
